// File: rtl/mem_rr_arbiter.sv
// Two-requester round-robin arbiter sequencing single transactions onto a valid/ready memory port.
// Optional BUSY watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_rr_arbiter #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  r0_valid,
    input  logic                  r0_wr_rd,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [WIDTH-1:0]      r0_wdata,
    output logic                  r0_ready,
    output logic [WIDTH-1:0]      r0_rdata,
    output logic                  r0_err,
    input  logic                  r1_valid,
    input  logic                  r1_wr_rd,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [WIDTH-1:0]      r1_wdata,
    output logic                  r1_ready,
    output logic [WIDTH-1:0]      r1_rdata,
    output logic                  r1_err,
    output logic                  m_valid,
    output logic                  m_wr_rd,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [WIDTH-1:0]      m_wdata,
    input  logic                  m_ready,
    input  logic [WIDTH-1:0]      m_rdata,
    output logic                  gnt,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    if (TIMEOUT < 1) begin : g_timeout_check
        $error("mem_rr_arbiter: TIMEOUT must be at least 1");
    end

    state_t                state_q, state_d;
    logic                  ptr_q, ptr_d;
    logic                  gnt_q, gnt_d;
    logic                  busy_q, busy_d;
    logic                  mv_q, mv_d;
    logic                  mwr_q, mwr_d;
    logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
    logic [WIDTH-1:0]      mwdata_q, mwdata_d;
    logic [1:0]            rdy_q, rdy_d;
    logic [1:0]            err_q, err_d;
    logic [WIDTH-1:0]      r0_rdata_q, r0_rdata_d;
    logic [WIDTH-1:0]      r1_rdata_q, r1_rdata_d;

    logic                  sel;
    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [WIDTH-1:0]      sel_wdata;
    logic                  fin;
    logic                  fin_err;
    logic [WIDTH-1:0]      fin_data;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    // Lone requester wins outright; on a tie the one not granted last time wins.
    always_comb begin
        sel       = (r0_valid && r1_valid) ? ~ptr_q : r1_valid;
        sel_wr    = sel ? r1_wr_rd : r0_wr_rd;
        sel_addr  = sel ? r1_addr  : r0_addr;
        sel_wdata = sel ? r1_wdata : r0_wdata;
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        mv_d       = mv_q;
        mwr_d      = mwr_q;
        maddr_d    = maddr_q;
        mwdata_d   = mwdata_q;
        rdy_d      = '0;
        err_d      = '0;
        r0_rdata_d = '0;
        r1_rdata_d = '0;
        fin        = 1'b0;
        fin_err    = 1'b0;
        fin_data   = '0;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                mv_d     = 1'b0;
                mwr_d    = 1'b0;
                maddr_d  = '0;
                mwdata_d = '0;
                if (r0_valid || r1_valid) begin
                    state_d  = S_BUSY;
                    gnt_d    = sel;
                    mv_d     = 1'b1;
                    mwr_d    = sel_wr;
                    maddr_d  = sel_addr;
                    mwdata_d = sel_wr ? sel_wdata : '0;
`ifdef MEM_ARB_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end

            S_BUSY: begin
                if (m_ready) begin
                    fin      = 1'b1;
                    fin_data = mwr_q ? '0 : m_rdata;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                // m_ready takes priority over an expiry landing in the same cycle.
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
                if (fin) begin
                    state_d       = S_DONE;
                    mv_d          = 1'b0;
                    mwr_d         = 1'b0;
                    maddr_d       = '0;
                    mwdata_d      = '0;
                    ptr_d         = gnt_q;
                    rdy_d[gnt_q]  = 1'b1;
                    err_d[gnt_q]  = fin_err;
                    if (gnt_q) r1_rdata_d = fin_data;
                    else       r0_rdata_d = fin_data;
                end
            end

            S_DONE: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q    <= S_IDLE;
            ptr_q      <= 1'b1;
            gnt_q      <= 1'b0;
            busy_q     <= 1'b0;
            mv_q       <= 1'b0;
            mwr_q      <= 1'b0;
            maddr_q    <= '0;
            mwdata_q   <= '0;
            rdy_q      <= '0;
            err_q      <= '0;
            r0_rdata_q <= '0;
            r1_rdata_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            busy_q     <= busy_d;
            mv_q       <= mv_d;
            mwr_q      <= mwr_d;
            maddr_q    <= maddr_d;
            mwdata_q   <= mwdata_d;
            rdy_q      <= rdy_d;
            err_q      <= err_d;
            r0_rdata_q <= r0_rdata_d;
            r1_rdata_q <= r1_rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign r0_ready = rdy_q[0];
    assign r1_ready = rdy_q[1];
    assign r0_err   = err_q[0];
    assign r1_err   = err_q[1];
    assign r0_rdata = r0_rdata_q;
    assign r1_rdata = r1_rdata_q;
    assign m_valid  = mv_q;
    assign m_wr_rd  = mwr_q;
    assign m_addr   = maddr_q;
    assign m_wdata  = mwdata_q;
    assign gnt      = gnt_q;
    assign busy     = busy_q;

endmodule
